// File: rtl/psum_pkg.sv
// psum_pkg
// Shared types and constants for the partial-sum accumulator slice.
//   state_t        : job FSM states (IDLE, ACCUM, DRAIN)
//   PSUM_W/LANE_W  : incoming psum width and per-lane width in split mode
//   SHIFT_W        : width of the per-beat shift field
//   MAX_SHIFT      : largest shift applied; larger requests clamp to this
//   ACC_W_DEFAULT  : default accumulator/output lane width
package psum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int PSUM_W        = 18;
  localparam int LANE_W        = 9;
  localparam int SHIFT_W       = 4;
  localparam int MAX_SHIFT     = 12;
  localparam int ACC_W_DEFAULT = 32;

endpackage

// File: rtl/psum_lane_ext.sv
// psum_lane_ext
// Combinational lane conditioner: extends a raw lane to ACC_W bits and
// applies the per-beat left shift so the result can be added directly
// into an accumulator.
//   lane_raw  in  PSUM_W   raw lane; only [LANE_W-1:0] is used when split=1
//   split     in  1        1: lane is LANE_W bits wide; 0: full PSUM_W bits
//   is_signed in  1        1: sign-extend; 0: zero-extend
//   shift     in  SHIFT_W  left shift, values above MAX_SHIFT clamp
//   addend    out ACC_W    extended and shifted addend
module psum_lane_ext
  import psum_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEFAULT
) (
  input  logic [PSUM_W-1:0]  lane_raw,
  input  logic               split,
  input  logic               is_signed,
  input  logic [SHIFT_W-1:0] shift,
  output logic [ACC_W-1:0]   addend
);

  logic [ACC_W-1:0]   ext;
  logic [SHIFT_W-1:0] eff_shift;

  // Extend from whichever bit is the lane's sign bit, then shift. Shift
  // requests beyond MAX_SHIFT saturate rather than wrap so a bad shift
  // code cannot push the operand into unexpected bit positions.
  always_comb begin
    ext       = '0;
    eff_shift = shift;
    if (split) begin
      ext = {{(ACC_W-LANE_W){is_signed & lane_raw[LANE_W-1]}}, lane_raw[LANE_W-1:0]};
    end else begin
      ext = {{(ACC_W-PSUM_W){is_signed & lane_raw[PSUM_W-1]}}, lane_raw};
    end
    if (shift > SHIFT_W'(MAX_SHIFT)) begin
      eff_shift = SHIFT_W'(MAX_SHIFT);
    end
    addend = ext << eff_shift;
  end

endmodule

// File: rtl/psum_accumulator.sv
// psum_accumulator
// Accumulates the fusion-unit partial-sum stream over a configured
// reduction length and presents the one- or two-lane result downstream.
//   clk, rst          clock, synchronous active-high reset
//   cfg_valid/ready   job descriptor handshake (ready only in IDLE)
//   cfg_len           psums per result, 0 means 2^LEN_W
//   cfg_split         1: two packed 9-bit lanes; 0: one 18-bit total
//   cfg_signed        1: sign-extend lanes; 0: zero-extend
//   psum_valid/ready  psum beat handshake (ready only in ACCUM)
//   psum_in           18-bit partial sum
//   psum_shift        per-beat left shift, 13..15 act as 12
//   out_valid/ready   result handshake (valid only in DRAIN)
//   out_acc0/out_acc1 lane-0 (or total) and lane-1 results
//   busy              high whenever a job is in progress
module psum_accumulator
  import psum_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEFAULT,
  parameter int LEN_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_split,
  input  logic               cfg_signed,
  input  logic               psum_valid,
  output logic               psum_ready,
  input  logic [PSUM_W-1:0]  psum_in,
  input  logic [SHIFT_W-1:0] psum_shift,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_acc0,
  output logic [ACC_W-1:0]   out_acc1,
  output logic               busy
);

  state_t             state;
  state_t             next_state;
  logic [LEN_W-1:0]   len_q;
  logic               split_q;
  logic               signed_q;
  logic [LEN_W-1:0]   count;
  logic [ACC_W-1:0]   acc0;
  logic [ACC_W-1:0]   acc1;
  logic [ACC_W-1:0]   addend0;
  logic [ACC_W-1:0]   addend1;
  logic [PSUM_W-1:0]  lane1_raw;
  logic               cfg_fire;
  logic               beat_fire;
  logic               last_beat;

  // Acceptance is qualified by the registered state, never by the
  // handshake outputs, so the outputs stay pure functions of state.
  assign cfg_fire  = (state == IDLE)  && cfg_valid;
  assign beat_fire = (state == ACCUM) && psum_valid;

  // len_q - 1 wraps to all-ones when len_q is 0, which gives the
  // 2^LEN_W reduction length without a wider counter.
  assign last_beat = (count == (len_q - LEN_W'(1)));

  // Lane 1 only carries data in split mode; in total mode it adds zero.
  assign lane1_raw = split_q ? {{(PSUM_W-LANE_W){1'b0}}, psum_in[PSUM_W-1:LANE_W]} : '0;

  psum_lane_ext #(.ACC_W(ACC_W)) u_lane0 (
    .lane_raw  (psum_in),
    .split     (split_q),
    .is_signed (signed_q),
    .shift     (psum_shift),
    .addend    (addend0)
  );

  psum_lane_ext #(.ACC_W(ACC_W)) u_lane1 (
    .lane_raw  (lane1_raw),
    .split     (split_q),
    .is_signed (signed_q),
    .shift     (psum_shift),
    .addend    (addend1)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and handshake decode. Outputs depend only on the current
  // state; DRAIN always returns through IDLE so a new descriptor can only
  // land the cycle after the result handshake.
  always_comb begin
    next_state = state;
    cfg_ready  = 1'b0;
    psum_ready = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        cfg_ready = 1'b1;
        busy      = 1'b0;
        if (cfg_valid) begin
          next_state = ACCUM;
        end
      end
      ACCUM: begin
        psum_ready = 1'b1;
        if (psum_valid && last_beat) begin
          next_state = DRAIN;
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (out_ready) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Job configuration, beat counter and accumulators. Sums wrap modulo
  // 2^ACC_W by design; the accumulators double as the output registers
  // and simply hold while DRAIN waits for the downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q    <= '0;
      split_q  <= 1'b0;
      signed_q <= 1'b0;
      count    <= '0;
      acc0     <= '0;
      acc1     <= '0;
    end else if (cfg_fire) begin
      len_q    <= cfg_len;
      split_q  <= cfg_split;
      signed_q <= cfg_signed;
      count    <= '0;
      acc0     <= '0;
      acc1     <= '0;
    end else if (beat_fire) begin
      count <= count + LEN_W'(1);
      acc0  <= acc0 + addend0;
      acc1  <= acc1 + addend1;
    end
  end

  assign out_acc0 = acc0;
  assign out_acc1 = acc1;

endmodule

// File: tb/tb_psum_accumulator.sv
// tb_psum_accumulator
// Directed testbench for psum_accumulator. Each scenario task drives its
// own stimulus and compares outputs against hand-computed values.
module tb_psum_accumulator;

  logic        clk;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [7:0]  cfg_len;
  logic        cfg_split;
  logic        cfg_signed;
  logic        psum_valid;
  logic        psum_ready;
  logic [17:0] psum_in;
  logic [3:0]  psum_shift;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_acc0;
  logic [31:0] out_acc1;
  logic        busy;

  int checks;
  int errors;

  psum_accumulator #(.ACC_W(32), .LEN_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_len    (cfg_len),
    .cfg_split  (cfg_split),
    .cfg_signed (cfg_signed),
    .psum_valid (psum_valid),
    .psum_ready (psum_ready),
    .psum_in    (psum_in),
    .psum_shift (psum_shift),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_acc0   (out_acc0),
    .out_acc1   (out_acc1),
    .busy       (busy)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and settle 1 unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a descriptor for exactly one edge (DUT is assumed in IDLE).
  task automatic start_job(input logic [7:0] len, input logic split, input logic sgn);
    cfg_valid  = 1'b1;
    cfg_len    = len;
    cfg_split  = split;
    cfg_signed = sgn;
    step();
    cfg_valid  = 1'b0;
    cfg_len    = 8'hAA;
    cfg_split  = ~split;
    cfg_signed = ~sgn;
  endtask

  // Present one psum beat for exactly one edge.
  task automatic send_beat(input logic [17:0] data, input logic [3:0] shift);
    psum_valid = 1'b1;
    psum_in    = data;
    psum_shift = shift;
    step();
    psum_valid = 1'b0;
  endtask

  // Accept the result with a single-edge out_ready pulse.
  task automatic take_result();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_cfg_ready: got %b expected 1", cfg_ready); end
    checks++; if (psum_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_psum_ready: got %b expected 0", psum_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (out_acc0 !== 32'd0) begin errors++; $display("[TB] FAIL reset_acc0: got %0h expected 0", out_acc0); end
    checks++; if (out_acc1 !== 32'd0) begin errors++; $display("[TB] FAIL reset_acc1: got %0h expected 0", out_acc1); end
  endtask

  task automatic test_unsigned_total();
    start_job(8'd3, 1'b0, 1'b0);
    checks++; if (psum_ready !== 1'b1) begin errors++; $display("[TB] FAIL total_psum_ready: got %b expected 1", psum_ready); end
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("[TB] FAIL total_cfg_ready: got %b expected 0", cfg_ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL total_busy: got %b expected 1", busy); end
    send_beat(18'd5, 4'd0);
    send_beat(18'd10, 4'd0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL total_early_valid: got %b expected 0", out_valid); end
    send_beat(18'd20, 4'd0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL total_out_valid: got %b expected 1", out_valid); end
    checks++; if (psum_ready !== 1'b0) begin errors++; $display("[TB] FAIL total_drain_psum_ready: got %b expected 0", psum_ready); end
    checks++; if (out_acc0 !== 32'd35) begin errors++; $display("[TB] FAIL total_acc0: got %0d expected 35", out_acc0); end
    checks++; if (out_acc1 !== 32'd0) begin errors++; $display("[TB] FAIL total_acc1: got %0d expected 0", out_acc1); end
    take_result();
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("[TB] FAIL total_done_cfg_ready: got %b expected 1", cfg_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL total_done_out_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_signed_split();
    start_job(8'd2, 1'b1, 1'b1);
    send_beat({9'h1FF, 9'h003}, 4'd0);
    send_beat({9'h1FF, 9'h003}, 4'd0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL split_out_valid: got %b expected 1", out_valid); end
    checks++; if (out_acc0 !== 32'd6) begin errors++; $display("[TB] FAIL split_acc0: got %0h expected 6", out_acc0); end
    checks++; if (out_acc1 !== 32'hFFFFFFFE) begin errors++; $display("[TB] FAIL split_acc1: got %0h expected fffffffe", out_acc1); end
    take_result();
    // Unsigned split: 0x1FF zero-extends to 511 per beat.
    start_job(8'd2, 1'b1, 1'b0);
    send_beat({9'h1FF, 9'h003}, 4'd1);
    send_beat({9'h1FF, 9'h003}, 4'd0);
    checks++; if (out_acc0 !== 32'd9) begin errors++; $display("[TB] FAIL usplit_acc0: got %0d expected 9", out_acc0); end
    checks++; if (out_acc1 !== 32'd1533) begin errors++; $display("[TB] FAIL usplit_acc1: got %0d expected 1533", out_acc1); end
    take_result();
  endtask

  task automatic test_shift();
    start_job(8'd4, 1'b0, 1'b0);
    send_beat(18'd1, 4'd0);
    send_beat(18'd1, 4'd4);
    send_beat(18'd1, 4'd4);
    send_beat(18'd1, 4'd8);
    checks++; if (out_acc0 !== 32'd289) begin errors++; $display("[TB] FAIL shift_compose_acc0: got %0d expected 289", out_acc0); end
    take_result();
    start_job(8'd1, 1'b0, 1'b0);
    send_beat(18'd1, 4'd15);
    checks++; if (out_acc0 !== 32'd4096) begin errors++; $display("[TB] FAIL shift_clamp15_acc0: got %0d expected 4096", out_acc0); end
    take_result();
    start_job(8'd2, 1'b0, 1'b0);
    send_beat(18'd3, 4'd13);
    send_beat(18'd1, 4'd12);
    checks++; if (out_acc0 !== 32'd16384) begin errors++; $display("[TB] FAIL shift_clamp13_acc0: got %0d expected 16384", out_acc0); end
    take_result();
  endtask

  task automatic test_backpressure();
    start_job(8'd1, 1'b0, 1'b0);
    send_beat(18'd9, 4'd2);
    for (int i = 0; i < 5; i++) begin
      psum_valid = i[0];
      psum_in    = 18'd100;
      psum_shift = 4'd0;
      cfg_valid  = 1'b1;
      out_ready  = 1'b0;
      step();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_out_valid[%0d]: got %b expected 1", i, out_valid); end
      checks++; if (out_acc0 !== 32'd36) begin errors++; $display("[TB] FAIL bp_acc0[%0d]: got %0d expected 36", i, out_acc0); end
      checks++; if (psum_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_psum_ready[%0d]: got %b expected 0", i, psum_ready); end
      checks++; if (cfg_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_cfg_ready[%0d]: got %b expected 0", i, cfg_ready); end
    end
    psum_valid = 1'b0;
    // Descriptor held across the handshake edge must not be taken yet.
    cfg_valid = 1'b1;
    cfg_len   = 8'd1;
    take_result();
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_after_cfg_ready: got %b expected 1", cfg_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL bp_no_bypass_busy: got %b expected 0", busy); end
    cfg_valid = 1'b0;
    send_beat(18'd5, 4'd0);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_beat_busy: got %b expected 0", busy); end
    checks++; if (out_acc0 !== 32'd36) begin errors++; $display("[TB] FAIL idle_beat_acc0: got %0d expected 36", out_acc0); end
  endtask

  task automatic test_reset_mid_job();
    start_job(8'd4, 1'b0, 1'b0);
    send_beat(18'd3, 4'd0);
    send_beat(18'd4, 4'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_cfg_ready: got %b expected 1", cfg_ready); end
    checks++; if (psum_ready !== 1'b0) begin errors++; $display("[TB] FAIL midrst_psum_ready: got %b expected 0", psum_ready); end
    checks++; if (out_acc0 !== 32'd0) begin errors++; $display("[TB] FAIL midrst_acc0: got %0d expected 0", out_acc0); end
    start_job(8'd1, 1'b0, 1'b0);
    send_beat(18'd7, 4'd0);
    checks++; if (out_acc0 !== 32'd7) begin errors++; $display("[TB] FAIL midrst_next_acc0: got %0d expected 7", out_acc0); end
    // Reset while a result is pending drops out_valid.
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL drainrst_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_acc0 !== 32'd0) begin errors++; $display("[TB] FAIL drainrst_acc0: got %0d expected 0", out_acc0); end
  endtask

  task automatic test_len_zero();
    start_job(8'd0, 1'b0, 1'b0);
    for (int i = 0; i < 256; i++) begin
      send_beat(18'd1, 4'd0);
      if (i < 255) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL len0_early_valid[%0d]: got %b expected 0", i, out_valid); end
      end
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL len0_out_valid: got %b expected 1", out_valid); end
    checks++; if (out_acc0 !== 32'd256) begin errors++; $display("[TB] FAIL len0_acc0: got %0d expected 256", out_acc0); end
    take_result();
  endtask

  task automatic test_wrap();
    // Each beat adds -2^29 (0xE0000000); five beats wrap to 0x60000000.
    start_job(8'd5, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      send_beat(18'h20000, 4'd12);
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL wrap_out_valid: got %b expected 1", out_valid); end
    checks++; if (out_acc0 !== 32'h60000000) begin errors++; $display("[TB] FAIL wrap_acc0: got %0h expected 60000000", out_acc0); end
    checks++; if (out_acc1 !== 32'd0) begin errors++; $display("[TB] FAIL wrap_acc1: got %0h expected 0", out_acc1); end
    take_result();
  endtask

  // Scenario sequencing.
  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    cfg_valid  = 1'b0;
    cfg_len    = 8'd0;
    cfg_split  = 1'b0;
    cfg_signed = 1'b0;
    psum_valid = 1'b0;
    psum_in    = 18'd0;
    psum_shift = 4'd0;
    out_ready  = 1'b0;
    #2;
    $display("[TB] starting psum_accumulator tests");
    test_reset();
    test_unsigned_total();
    test_signed_split();
    test_shift();
    test_backpressure();
    test_reset_mid_job();
    test_len_zero();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
